// File: rtl/cricket_pkg.sv
// -----------------------------------------------------------------------------
// cricket_pkg
// Shared types and constants for the T20 match controller.
//   match_state_t : controller FSM states (IDLE, INN1, BREAK, INN2, DONE)
//   winner_t      : published result encoding (NONE=00, T1=01, T2=10, TIE=11)
//   RUNS_W/WKT_W/BALL_W : tally widths; MAX_RUNS_PER_BALL : cap on runs_scored
// -----------------------------------------------------------------------------
package cricket_pkg;

    localparam int RUNS_W            = 8;
    localparam int WKT_W             = 4;
    localparam int BALL_W            = 7;
    localparam int MAX_RUNS_PER_BALL = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INN1  = 3'd1,
        ST_BREAK = 3'd2,
        ST_INN2  = 3'd3,
        ST_DONE  = 3'd4
    } match_state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_T1   = 2'b01,
        WIN_T2   = 2'b10,
        WIN_TIE  = 2'b11
    } winner_t;

endpackage

// File: rtl/innings_tally.sv
// -----------------------------------------------------------------------------
// innings_tally
// One team's runs / wickets / legal-ball tally.
//   clk, rst      : clock, asynchronous active-low reset
//   clear         : synchronous clear of all three tallies (new match)
//   en            : apply the presented delivery on this edge
//   runs_scored   : runs off the bat, 7 is treated as 6
//   is_extra      : wide/no-ball, +1 penalty run, ball and wicket not counted
//   is_wicket     : wicket on a legal delivery
//   runs/wickets/balls : current tallies (runs saturate, balls and wickets cap)
// -----------------------------------------------------------------------------
module innings_tally
    import cricket_pkg::*;
#(
    parameter int MAX_BALLS   = 120,
    parameter int MAX_WICKETS = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [2:0]        runs_scored,
    input  logic              is_extra,
    input  logic              is_wicket,
    output logic [RUNS_W-1:0] runs,
    output logic [WKT_W-1:0]  wickets,
    output logic [BALL_W-1:0] balls
);

    // Total runs credited for one delivery, including the extra's penalty run.
    function automatic logic [3:0] delivery_runs(input logic [2:0] rs, input logic extra);
        logic [3:0] r;
        r = (rs == 3'd7) ? 4'(MAX_RUNS_PER_BALL) : {1'b0, rs};
        return extra ? r + 4'd1 : r;
    endfunction

    // Saturating add onto the running total.
    function automatic logic [RUNS_W-1:0] sat_runs(input logic [RUNS_W-1:0] cur,
                                                   input logic [3:0]        add);
        logic [RUNS_W:0] sum;
        sum = {1'b0, cur} + (RUNS_W+1)'(add);
        return sum[RUNS_W] ? {RUNS_W{1'b1}} : sum[RUNS_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            runs    <= '0;
            wickets <= '0;
            balls   <= '0;
        end else if (clear) begin
            runs    <= '0;
            wickets <= '0;
            balls   <= '0;
        end else if (en) begin
            runs <= sat_runs(runs, delivery_runs(runs_scored, is_extra));
            if (!is_extra) begin
                if (balls != BALL_W'(MAX_BALLS))
                    balls <= balls + BALL_W'(1);
                if (is_wicket && (wickets != WKT_W'(MAX_WICKETS)))
                    wickets <= wickets + WKT_W'(1);
            end
        end
    end

endmodule

// File: rtl/match_controller.sv
// -----------------------------------------------------------------------------
// match_controller
// Sequences a T20 match: IDLE -> INN1 -> BREAK -> INN2 -> DONE.
//   clk, rst            : clock, asynchronous active-low reset
//   start               : begin (or restart) a match, honoured in IDLE/DONE
//   ball_valid, runs_scored, is_extra, is_wicket : one delivery per cycle
//   ball_ack            : registered acknowledge of an accepted delivery
//   team1_*/team_1_ball, team2_*/team_2_ball : per-team tallies
//   batting_team        : 0 = team 1, 1 = team 2
//   target              : team1_runs+1 once innings 1 has ended, else 0
//   innings_over        : one-cycle pulse when an innings ends
//   game_over, winner   : DONE flag and result (cricket_pkg::winner_t)
// -----------------------------------------------------------------------------
module match_controller
    import cricket_pkg::*;
#(
    parameter int MAX_BALLS    = 120,
    parameter int MAX_WICKETS  = 10,
    parameter int BREAK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ball_valid,
    input  logic [2:0]        runs_scored,
    input  logic              is_extra,
    input  logic              is_wicket,
    output logic              ball_ack,
    output logic [RUNS_W-1:0] team1_runs,
    output logic [WKT_W-1:0]  team1_wickets,
    output logic [BALL_W-1:0] team_1_ball,
    output logic [RUNS_W-1:0] team2_runs,
    output logic [WKT_W-1:0]  team2_wickets,
    output logic [BALL_W-1:0] team_2_ball,
    output logic              batting_team,
    output logic [8:0]        target,
    output logic              innings_over,
    output logic              game_over,
    output logic [1:0]        winner
);

    localparam int CNT_W = $clog2(BREAK_CYCLES) + 1;

    match_state_t     state;
    winner_t          win_q;
    logic [CNT_W-1:0] brk_cnt;

    logic begin_match, t1_limit, t2_limit, chase, inn1_end, inn2_end;
    logic accept, en1, en2;

    function automatic winner_t decide_winner(input logic [RUNS_W-1:0] r1,
                                              input logic [RUNS_W-1:0] r2);
        if (r1 > r2)      return WIN_T1;
        else if (r1 < r2) return WIN_T2;
        else              return WIN_TIE;
    endfunction

    assign begin_match = start && ((state == ST_IDLE) || (state == ST_DONE));

    // End conditions look at the tallies already updated by the last delivery,
    // so the innings closes one cycle after the ending ball.
    assign t1_limit = (team_1_ball == BALL_W'(MAX_BALLS)) || (team1_wickets == WKT_W'(MAX_WICKETS));
    assign t2_limit = (team_2_ball == BALL_W'(MAX_BALLS)) || (team2_wickets == WKT_W'(MAX_WICKETS));
    assign chase    = ({1'b0, team2_runs} >= target);
    assign inn1_end = (state == ST_INN1) && t1_limit;
    assign inn2_end = (state == ST_INN2) && (chase || t2_limit);

    // Deliveries arriving in the closing cycle of an innings are dropped.
    assign accept = ball_valid && (((state == ST_INN1) && !inn1_end) ||
                                   ((state == ST_INN2) && !inn2_end));
    assign en1    = accept && (state == ST_INN1);
    assign en2    = accept && (state == ST_INN2);

    innings_tally #(.MAX_BALLS(MAX_BALLS), .MAX_WICKETS(MAX_WICKETS)) u_team1 (
        .clk         (clk),
        .rst         (rst),
        .clear       (begin_match),
        .en          (en1),
        .runs_scored (runs_scored),
        .is_extra    (is_extra),
        .is_wicket   (is_wicket),
        .runs        (team1_runs),
        .wickets     (team1_wickets),
        .balls       (team_1_ball)
    );

    innings_tally #(.MAX_BALLS(MAX_BALLS), .MAX_WICKETS(MAX_WICKETS)) u_team2 (
        .clk         (clk),
        .rst         (rst),
        .clear       (begin_match),
        .en          (en2),
        .runs_scored (runs_scored),
        .is_extra    (is_extra),
        .is_wicket   (is_wicket),
        .runs        (team2_runs),
        .wickets     (team2_wickets),
        .balls       (team_2_ball)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            win_q        <= WIN_NONE;
            brk_cnt      <= '0;
            batting_team <= 1'b0;
            target       <= '0;
            ball_ack     <= 1'b0;
            innings_over <= 1'b0;
        end else begin
            ball_ack     <= accept;
            innings_over <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (begin_match) begin
                        state        <= ST_INN1;
                        batting_team <= 1'b0;
                        target       <= '0;
                        win_q        <= WIN_NONE;
                    end
                end
                ST_INN1: begin
                    if (inn1_end) begin
                        state        <= ST_BREAK;
                        target       <= {1'b0, team1_runs} + 9'd1;
                        brk_cnt      <= '0;
                        innings_over <= 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (brk_cnt == CNT_W'(BREAK_CYCLES - 1)) begin
                        state        <= ST_INN2;
                        batting_team <= 1'b1;
                    end else begin
                        brk_cnt <= brk_cnt + CNT_W'(1);
                    end
                end
                ST_INN2: begin
                    // A chase always leaves team 2 ahead, so the plain score
                    // comparison already gives the chase priority over limits.
                    if (inn2_end) begin
                        state        <= ST_DONE;
                        innings_over <= 1'b1;
                        win_q        <= decide_winner(team1_runs, team2_runs);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign game_over = (state == ST_DONE);
    assign winner    = win_q;

endmodule

// File: tb/tb_match_controller.sv
module tb_match_controller;

    localparam int MB = 120;
    localparam int MW = 10;
    localparam int BC = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       ball_valid;
    logic [2:0] runs_scored;
    logic       is_extra;
    logic       is_wicket;
    logic       ball_ack;
    logic [7:0] team1_runs;
    logic [3:0] team1_wickets;
    logic [6:0] team_1_ball;
    logic [7:0] team2_runs;
    logic [3:0] team2_wickets;
    logic [6:0] team_2_ball;
    logic       batting_team;
    logic [8:0] target;
    logic       innings_over;
    logic       game_over;
    logic [1:0] winner;

    always #5 clk = ~clk;

    match_controller #(.MAX_BALLS(MB), .MAX_WICKETS(MW), .BREAK_CYCLES(BC)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .ball_valid    (ball_valid),
        .runs_scored   (runs_scored),
        .is_extra      (is_extra),
        .is_wicket     (is_wicket),
        .ball_ack      (ball_ack),
        .team1_runs    (team1_runs),
        .team1_wickets (team1_wickets),
        .team_1_ball   (team_1_ball),
        .team2_runs    (team2_runs),
        .team2_wickets (team2_wickets),
        .team_2_ball   (team_2_ball),
        .batting_team  (batting_team),
        .target        (target),
        .innings_over  (innings_over),
        .game_over     (game_over),
        .winner        (winner)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int over_pulses = 0;

    // Reference model: phase 0 idle, 1 first innings, 2 break, 3 chase, 4 result.
    int m_phase;
    int m_runs[2];
    int m_wk[2];
    int m_bl[2];
    int m_bat, m_target, m_winner, m_ack, m_over, m_brk, m_ending;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_phase = 0;
        for (int t = 0; t < 2; t++) begin
            m_runs[t] = 0; m_wk[t] = 0; m_bl[t] = 0;
        end
        m_bat = 0; m_target = 0; m_winner = 0;
        m_ack = 0; m_over = 0; m_brk = 0; m_ending = 0;
    endtask

    task automatic model_apply(input int t);
        int r;
        r = (runs_scored == 3'd7) ? 6 : int'(runs_scored);
        if (is_extra) r = r + 1;
        m_runs[t] = (m_runs[t] + r > 255) ? 255 : m_runs[t] + r;
        if (!is_extra) begin
            if (m_bl[t] < MB) m_bl[t]++;
            if (is_wicket && m_wk[t] < MW) m_wk[t]++;
        end
        if (m_bl[t] == MB || m_wk[t] == MW || (t == 1 && m_runs[1] >= m_target))
            m_ending = 1;
    endtask

    task automatic model_step();
        int nack, nover;
        if (!rst) begin
            model_reset();
            return;
        end
        nack = 0; nover = 0;
        case (m_phase)
            0, 4: if (start) begin
                model_reset();
                m_phase = 1;
            end
            1, 3: begin
                if (m_ending) begin
                    nover = 1;
                    m_ending = 0;
                    if (m_phase == 1) begin
                        m_target = m_runs[0] + 1;
                        m_phase = 2;
                        m_brk = BC;
                    end else begin
                        m_phase = 4;
                        m_winner = (m_runs[0] > m_runs[1]) ? 1 : (m_runs[0] < m_runs[1]) ? 2 : 3;
                    end
                end else if (ball_valid) begin
                    model_apply(m_phase == 1 ? 0 : 1);
                    nack = 1;
                end
            end
            2: begin
                m_brk--;
                if (m_brk == 0) begin
                    m_phase = 3;
                    m_bat = 1;
                end
            end
            default: ;
        endcase
        m_ack = nack;
        m_over = nover;
    endtask

    task automatic compare_all();
        chk("ball_ack",      int'(ball_ack),      m_ack);
        chk("team1_runs",    int'(team1_runs),    m_runs[0]);
        chk("team1_wickets", int'(team1_wickets), m_wk[0]);
        chk("team_1_ball",   int'(team_1_ball),   m_bl[0]);
        chk("team2_runs",    int'(team2_runs),    m_runs[1]);
        chk("team2_wickets", int'(team2_wickets), m_wk[1]);
        chk("team_2_ball",   int'(team_2_ball),   m_bl[1]);
        chk("batting_team",  int'(batting_team),  m_bat);
        chk("target",        int'(target),        m_target);
        chk("innings_over",  int'(innings_over),  m_over);
        chk("game_over",     int'(game_over),     (m_phase == 4) ? 1 : 0);
        chk("winner",        int'(winner),        m_winner);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
        compare_all();
        if (innings_over) over_pulses++;
    endtask

    task automatic deliver(input int r, input bit ex, input bit wk);
        runs_scored = 3'(r);
        is_extra    = ex;
        is_wicket   = wk;
        ball_valid  = 1'b1;
        tick();
        ball_valid  = 1'b0;
        is_extra    = 1'b0;
        is_wicket   = 1'b0;
        runs_scored = 3'd0;
    endtask

    task automatic idle_until(input int ph, input int budget);
        int n;
        n = 0;
        while (m_phase != ph && n < budget) begin
            tick();
            n++;
        end
        if (m_phase != ph) begin
            n_checks++;
            $display("FAIL wait_phase: phase %0d after %0d cycles, required %0d", m_phase, n, ph);
        end
    endtask

    task automatic start_match();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int k;
        rst = 1'b0; start = 1'b0; ball_valid = 1'b0;
        runs_scored = 3'd0; is_extra = 1'b0; is_wicket = 1'b0;
        model_reset();

        // Reset state
        tick(); tick();
        chk("rst_team1_runs", int'(team1_runs), 0);
        chk("rst_target",     int'(target), 0);
        chk("rst_game_over",  int'(game_over), 0);
        chk("rst_winner",     int'(winner), 0);
        rst = 1'b1;
        tick();

        // 120 singles in innings 1, then the break
        start_match();
        over_pulses = 0;
        for (int i = 0; i < MB; i++) deliver(1, 0, 0);
        deliver(1, 0, 0);                       // closing cycle: dropped
        chk("s1_team1_runs", int'(team1_runs), 120);
        chk("s1_team1_ball", int'(team_1_ball), 120);
        chk("s1_target",     int'(target), 121);
        k = 0;
        while (m_phase == 2 && k < 40) begin
            deliver(3, 0, 0);                   // ignored in break
            k++;
        end
        chk("s1_break_len",   k, 16);
        chk("s1_batting",     int'(batting_team), 1);
        chk("s1_team2_runs",  int'(team2_runs), 0);
        chk("s1_over_pulses", over_pulses, 1);

        // All out for 0, one-run chase
        do_reset();
        start_match();
        for (int i = 0; i < 10; i++) deliver(0, 0, 1);
        idle_until(3, 40);
        chk("s2_team1_wk",   int'(team1_wickets), 10);
        chk("s2_team1_ball", int'(team_1_ball), 10);
        chk("s2_target",     int'(target), 1);
        deliver(1, 0, 0);
        tick();
        chk("s2_game_over", int'(game_over), 1);
        chk("s2_winner",    int'(winner), 2);
        for (int i = 0; i < 3; i++) deliver(4, 0, 0);   // ignored in DONE
        chk("s2_done_runs", int'(team2_runs), 1);
        chk("s2_done_ack",  int'(ball_ack), 0);

        // Tie via a wide, restart straight from DONE
        start_match();
        chk("s3_cleared_t2", int'(team2_runs), 0);
        chk("s3_cleared_win", int'(winner), 0);
        for (int i = 0; i < 30; i++) deliver(5, 0, 0);
        for (int i = 0; i < 90; i++) deliver(0, 0, 0);
        idle_until(3, 40);
        chk("s3_target", int'(target), 151);
        for (int i = 0; i < 29; i++) deliver(5, 0, 0);
        for (int i = 0; i < 4; i++)  deliver(1, 0, 0);
        deliver(0, 1, 0);
        chk("s3_wide_runs",  int'(team2_runs), 150);
        chk("s3_wide_balls", int'(team_2_ball), 33);
        start = 1'b1;                           // ignored mid-innings
        deliver(0, 0, 0);
        start = 1'b0;
        for (int i = 0; i < 86; i++) deliver(0, 0, 0);
        idle_until(4, 10);
        chk("s3_winner", int'(winner), 3);

        // Last-ball chase with the tenth wicket
        start_match();
        for (int i = 0; i < 100; i++) deliver(1, 0, 0);
        for (int i = 0; i < 20; i++)  deliver(0, 0, 0);
        idle_until(3, 40);
        for (int i = 0; i < 9; i++)  deliver(0, 0, 1);
        for (int i = 0; i < 95; i++) deliver(1, 0, 0);
        for (int i = 0; i < 15; i++) deliver(0, 0, 0);
        chk("s4_pre_runs",  int'(team2_runs), 95);
        chk("s4_pre_balls", int'(team_2_ball), 119);
        deliver(6, 0, 1);
        idle_until(4, 10);
        chk("s4_winner", int'(winner), 2);
        chk("s4_wk",     int'(team2_wickets), 10);
        chk("s4_runs",   int'(team2_runs), 101);

        // Saturation, then asynchronous reset mid-chase
        start_match();
        for (int i = 0; i < MB; i++) deliver(7, 0, 0);
        idle_until(3, 40);
        chk("s5_sat_runs", int'(team1_runs), 255);
        chk("s5_target",   int'(target), 256);
        for (int i = 0; i < 40; i++) deliver(2, 0, 0);
        chk("s5_t2_runs", int'(team2_runs), 80);
        #1 rst = 1'b0;
        #1;
        chk("s5_arst_t1_runs", int'(team1_runs), 0);
        chk("s5_arst_t2_runs", int'(team2_runs), 0);
        chk("s5_arst_t2_ball", int'(team_2_ball), 0);
        chk("s5_arst_bat",     int'(batting_team), 0);
        chk("s5_arst_target",  int'(target), 0);
        chk("s5_arst_ack",     int'(ball_ack), 0);
        model_reset();
        tick();
        rst = 1'b1;
        tick();

        // Randomized play
        for (int c = 0; c < 4000; c++) begin
            ball_valid  = ($urandom_range(0, 9) < 7);
            runs_scored = 3'($urandom_range(0, 7));
            is_extra    = ($urandom_range(0, 9) == 0);
            is_wicket   = ($urandom_range(0, 14) == 0);
            start       = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 1999) == 0) rst = 1'b0;
            tick();
            rst = 1'b1;
        end
        ball_valid = 1'b0; start = 1'b0; is_extra = 1'b0; is_wicket = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
